// File: rtl/panel_pkg.sv
// Shared types and helpers for the panel input conditioner: debounce channel state,
// default debounce length and counter sizing.
package panel_pkg;

   typedef enum logic {
      CH_IDLE    = 1'b0,
      CH_PENDING = 1'b1
   } ch_state_e;

   localparam int DEFAULT_DB_CYCLES = 500000;

   function automatic int cnt_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/panel_input_conditioner_if.sv
// Pin/PIO bundle of the panel input conditioner. The master side owns the raw pins and the
// capture-clear strobes; the slave side (the conditioner) returns the conditioned view.
interface panel_input_conditioner_if #(
   parameter int NUM_KEYS = 4,
   parameter int NUM_SW   = 4
);
   logic [NUM_KEYS-1:0] keys_n_i;
   logic [NUM_SW-1:0]   sw_i;
   logic [NUM_KEYS-1:0] key_clr_i;
   logic [NUM_KEYS-1:0] key_level_o;
   logic [NUM_KEYS-1:0] key_press_o;
   logic [NUM_KEYS-1:0] key_capture_o;
   logic [NUM_SW-1:0]   sw_level_o;
   logic                irq_o;

   modport master (
      output keys_n_i, sw_i, key_clr_i,
      input  key_level_o, key_press_o, key_capture_o, sw_level_o, irq_o
   );

   modport slave (
      input  keys_n_i, sw_i, key_clr_i,
      output key_level_o, key_press_o, key_capture_o, sw_level_o, irq_o
   );
endinterface

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchroniser followed by a stability counter. The level output is
// normalised so that 1 always means active, whatever the pin polarity.
module debounce_channel
   import panel_pkg::*;
#(
   parameter int DB_CYCLES  = DEFAULT_DB_CYCLES,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level
);
   localparam int           CW       = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
   localparam logic          IDLE_PIN = ACTIVE_LOW;

   logic          sync1_r;
   logic          sync2_r;
   logic [CW-1:0] cnt_r;
   logic          stable_r;
   logic          sample_s;
   ch_state_e     state_s;
   logic [CW-1:0] cnt_nxt_s;
   logic          stable_nxt_s;

   // Synchroniser, counter and accepted level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r  <= IDLE_PIN;
         sync2_r  <= IDLE_PIN;
         cnt_r    <= '0;
         stable_r <= 1'b0;
      end else begin
         sync1_r  <= pin;
         sync2_r  <= sync1_r;
         cnt_r    <= cnt_nxt_s;
         stable_r <= stable_nxt_s;
      end
   end

   // Count while the synchronised sample disagrees with the accepted level
   always_comb begin
      sample_s     = sync2_r ^ ACTIVE_LOW;
      state_s      = (sample_s != stable_r) ? CH_PENDING : CH_IDLE;
      cnt_nxt_s    = cnt_r;
      stable_nxt_s = stable_r;
      case (state_s)
         CH_IDLE: begin
            cnt_nxt_s = '0;
         end
         CH_PENDING: begin
            if (cnt_r == CNT_LAST) begin
               stable_nxt_s = sample_s;
               cnt_nxt_s    = '0;
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
         default: begin
            cnt_nxt_s = '0;
         end
      endcase
   end

   assign level = stable_r;

endmodule

// File: rtl/panel_input_conditioner.sv
// Debounces board keys and switches, turns key presses into pulses and sticky capture bits
// with an interrupt. Optional auto-repeat on held keys: define PANEL_AUTOREPEAT_EN.
module panel_input_conditioner
   import panel_pkg::*;
#(
   parameter int NUM_KEYS      = 4,
   parameter int NUM_SW        = 4,
   parameter int DB_CYCLES     = DEFAULT_DB_CYCLES,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset,
   panel_input_conditioner_if.slave bus
);
   logic [NUM_KEYS-1:0] key_level_s;
   logic [NUM_KEYS-1:0] key_rise_s;
   logic [NUM_KEYS-1:0] press_nxt_s;
   logic [NUM_KEYS-1:0] cap_nxt_s;
   logic [NUM_SW-1:0]   sw_level_s;
   logic [NUM_KEYS-1:0] level_d_r;
   logic [NUM_KEYS-1:0] press_r;
   logic [NUM_KEYS-1:0] cap_r;
   logic                irq_r;

   if ((DB_CYCLES < 2) || (REPEAT_PERIOD < 1) || (REPEAT_PERIOD > REPEAT_DELAY)) begin : g_bad_cfg
      $error("panel_input_conditioner: invalid DB_CYCLES / REPEAT_* configuration");
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      debounce_channel #(
         .DB_CYCLES  (DB_CYCLES),
         .ACTIVE_LOW (1'b1)
      ) u_db (
         .clk   (clk_clk),
         .rst_n (reset_reset),
         .pin   (bus.keys_n_i[i]),
         .level (key_level_s[i])
      );
   end

   for (genvar j = 0; j < NUM_SW; j++) begin : g_sw
      debounce_channel #(
         .DB_CYCLES  (DB_CYCLES),
         .ACTIVE_LOW (1'b0)
      ) u_db (
         .clk   (clk_clk),
         .rst_n (reset_reset),
         .pin   (bus.sw_i[j]),
         .level (sw_level_s[j])
      );
   end

`ifdef PANEL_AUTOREPEAT_EN
   localparam int            HW          = cnt_width(REPEAT_DELAY + 1);
   localparam logic [HW-1:0] HOLD_FIRE   = HW'(REPEAT_DELAY);
   localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

   logic [NUM_KEYS-1:0] repeat_s;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_hold
      logic [HW-1:0] hold_r;

      // Cycles held since the press pulse; reloading makes later repeats REPEAT_PERIOD apart
      always_ff @(posedge clk_clk or negedge reset_reset) begin
         if (!reset_reset) begin
            hold_r <= '0;
         end else if (!key_level_s[k]) begin
            hold_r <= '0;
         end else if (repeat_s[k]) begin
            hold_r <= HOLD_RELOAD;
         end else begin
            hold_r <= hold_r + HW'(1);
         end
      end

      assign repeat_s[k] = key_level_s[k] && (hold_r == HOLD_FIRE);
   end

   // Press pulse source: rising debounced level or auto-repeat tick
   always_comb begin
      key_rise_s  = key_level_s & ~level_d_r;
      press_nxt_s = key_rise_s | repeat_s;
      cap_nxt_s   = (cap_r & ~bus.key_clr_i) | press_r;
   end
`else
   // Press pulse source: rising debounced level only
   always_comb begin
      key_rise_s  = key_level_s & ~level_d_r;
      press_nxt_s = key_rise_s;
      cap_nxt_s   = (cap_r & ~bus.key_clr_i) | press_r;
   end
`endif

   // Press pulse, sticky capture (a press beats a coincident clear) and interrupt
   always_ff @(posedge clk_clk or negedge reset_reset) begin
      if (!reset_reset) begin
         level_d_r <= '0;
         press_r   <= '0;
         cap_r     <= '0;
         irq_r     <= 1'b0;
      end else begin
         level_d_r <= key_level_s;
         press_r   <= press_nxt_s;
         cap_r     <= cap_nxt_s;
         irq_r     <= |cap_r;
      end
   end

   assign bus.key_level_o   = key_level_s;
   assign bus.key_press_o   = press_r;
   assign bus.key_capture_o = cap_r;
   assign bus.sw_level_o    = sw_level_s;
   assign bus.irq_o         = irq_r;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Directed bench for panel_input_conditioner with DB_CYCLES=4; the auto-repeat sequence is
// compiled only when PANEL_AUTOREPEAT_EN is defined.
module tb_panel_input_conditioner;

   typedef struct {
      logic [3:0] keys_n;
      logic [3:0] sw;
      logic [3:0] clr;
      int         ticks;
      logic [3:0] level;
      logic [3:0] press;
      logic [3:0] cap;
      logic [3:0] sw_lvl;
      logic       irq;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   press_cnt [4];

   panel_input_conditioner_if #(.NUM_KEYS(4), .NUM_SW(4)) bus ();

   panel_input_conditioner #(
      .NUM_KEYS      (4),
      .NUM_SW        (4),
      .DB_CYCLES     (4),
      .REPEAT_DELAY  (20),
      .REPEAT_PERIOD (8)
   ) dut (
      .clk_clk     (clk),
      .reset_reset (rst_n),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 4; k++) begin
            press_cnt[k] += int'(bus.key_press_o[k]);
         end
      end
   end

   task automatic tick(input int n);
      for (int t = 0; t < n; t++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] level, input logic [3:0] press,
                            input logic [3:0] cap, input logic [3:0] sw_lvl, input logic irq);
      check({tag, " level"}, 32'(bus.key_level_o), 32'(level));
      check({tag, " press"}, 32'(bus.key_press_o), 32'(press));
      check({tag, " capture"}, 32'(bus.key_capture_o), 32'(cap));
      check({tag, " sw_level"}, 32'(bus.sw_level_o), 32'(sw_lvl));
      check({tag, " irq"}, 32'(bus.irq_o), 32'(irq));
   endtask

   function automatic vec_t mk(input logic [3:0] keys_n, input logic [3:0] sw, input logic [3:0] clr,
                               input int ticks, input logic [3:0] level, input logic [3:0] press,
                               input logic [3:0] cap, input logic [3:0] sw_lvl, input logic irq);
      vec_t v;
      v.keys_n = keys_n; v.sw = sw; v.clr = clr; v.ticks = ticks;
      v.level = level; v.press = press; v.cap = cap; v.sw_lvl = sw_lvl; v.irq = irq;
      return v;
   endfunction

   initial begin
      vec_t vecs [28];

      //                keys_n   sw       clr     tk  level    press    cap      sw_lvl   irq
      vecs[0]  = mk(4'hF, 4'h0, 4'h0, 2,  4'h0, 4'h0, 4'h0, 4'h0, 1'b0); // idle after reset
      vecs[1]  = mk(4'hE, 4'h0, 4'h0, 5,  4'h0, 4'h0, 4'h0, 4'h0, 1'b0); // key0 one clk early
      vecs[2]  = mk(4'hE, 4'h0, 4'h0, 1,  4'h1, 4'h0, 4'h0, 4'h0, 1'b0); // level at 6 clks
      vecs[3]  = mk(4'hE, 4'h0, 4'h0, 1,  4'h1, 4'h1, 4'h0, 4'h0, 1'b0); // press pulse
      vecs[4]  = mk(4'hE, 4'h0, 4'h0, 1,  4'h1, 4'h0, 4'h1, 4'h0, 1'b0); // capture set
      vecs[5]  = mk(4'hE, 4'h0, 4'h0, 1,  4'h1, 4'h0, 4'h1, 4'h0, 1'b1); // irq follows
      vecs[6]  = mk(4'hE, 4'h0, 4'h0, 10, 4'h1, 4'h0, 4'h1, 4'h0, 1'b1); // held, no more pulses
      vecs[7]  = mk(4'hF, 4'h0, 4'h0, 5,  4'h1, 4'h0, 4'h1, 4'h0, 1'b1); // release in debounce
      vecs[8]  = mk(4'hF, 4'h0, 4'h0, 1,  4'h0, 4'h0, 4'h1, 4'h0, 1'b1); // released
      vecs[9]  = mk(4'hF, 4'h0, 4'h0, 1,  4'h0, 4'h0, 4'h1, 4'h0, 1'b1); // no release pulse
      vecs[10] = mk(4'hB, 4'h0, 4'h0, 3,  4'h0, 4'h0, 4'h1, 4'h0, 1'b1); // key2 glitch
      vecs[11] = mk(4'hF, 4'h0, 4'h0, 6,  4'h0, 4'h0, 4'h1, 4'h0, 1'b1); // glitch rejected
      vecs[12] = mk(4'hF, 4'h0, 4'h1, 1,  4'h0, 4'h0, 4'h0, 4'h0, 1'b1); // clear key0
      vecs[13] = mk(4'hF, 4'h0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h0, 1'b0); // irq drops
      vecs[14] = mk(4'hF, 4'hA, 4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h0, 1'b0); // switch bounce
      vecs[15] = mk(4'hF, 4'h0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      vecs[16] = mk(4'hF, 4'hA, 4'h0, 5,  4'h0, 4'h0, 4'h0, 4'h0, 1'b0); // stable, one clk early
      vecs[17] = mk(4'hF, 4'hA, 4'h0, 1,  4'h0, 4'h0, 4'h0, 4'hA, 1'b0); // accepted, no irq
      vecs[18] = mk(4'hD, 4'hA, 4'h0, 6,  4'h2, 4'h0, 4'h0, 4'hA, 1'b0); // key1 level
      vecs[19] = mk(4'hD, 4'hA, 4'h0, 1,  4'h2, 4'h2, 4'h0, 4'hA, 1'b0);
      vecs[20] = mk(4'hD, 4'hA, 4'h0, 1,  4'h2, 4'h0, 4'h2, 4'hA, 1'b0);
      vecs[21] = mk(4'hD, 4'hA, 4'h0, 1,  4'h2, 4'h0, 4'h2, 4'hA, 1'b1);
      vecs[22] = mk(4'hF, 4'hA, 4'h0, 6,  4'h0, 4'h0, 4'h2, 4'hA, 1'b1); // key1 released
      vecs[23] = mk(4'hD, 4'hA, 4'h0, 7,  4'h2, 4'h2, 4'h2, 4'hA, 1'b1); // second press pulse
      vecs[24] = mk(4'hD, 4'hA, 4'h2, 1,  4'h2, 4'h0, 4'h2, 4'hA, 1'b1); // clear vs press: set wins
      vecs[25] = mk(4'hD, 4'hA, 4'h0, 1,  4'h2, 4'h0, 4'h2, 4'hA, 1'b1);
      vecs[26] = mk(4'hD, 4'hA, 4'h2, 1,  4'h2, 4'h0, 4'h0, 4'hA, 1'b1); // plain clear
      vecs[27] = mk(4'hD, 4'hA, 4'h0, 1,  4'h2, 4'h0, 4'h0, 4'hA, 1'b0);

      for (int k = 0; k < 4; k++) press_cnt[k] = 0;
      bus.keys_n_i  = 4'hF;
      bus.sw_i      = 4'h0;
      bus.key_clr_i = 4'h0;
      rst_n         = 1'b0;
      tick(2);
      rst_n = 1'b1;

      for (int i = 0; i < 28; i++) begin
         bus.keys_n_i  = vecs[i].keys_n;
         bus.sw_i      = vecs[i].sw;
         bus.key_clr_i = vecs[i].clr;
         tick(vecs[i].ticks);
         check_all($sformatf("v%0d", i), vecs[i].level, vecs[i].press, vecs[i].cap,
                   vecs[i].sw_lvl, vecs[i].irq);
      end
      bus.key_clr_i = 4'h0;

      // Reset in the middle of a key3 debounce with live outputs
      bus.keys_n_i = 4'h5;
      tick(3);
      rst_n = 1'b0;
      #1;
      check_all("reset_async", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      bus.keys_n_i = 4'hF;
      bus.sw_i     = 4'h0;
      tick(2);
      rst_n = 1'b1;
      tick(8);
      check_all("reset_idle", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

      check("pulses key0", 32'(press_cnt[0]), 32'd1);
      check("pulses key1", 32'(press_cnt[1]), 32'd2);
      check("pulses key2", 32'(press_cnt[2]), 32'd0);
      check("pulses key3", 32'(press_cnt[3]), 32'd0);

      // Key2 held through reset deassertion is taken as a new press
      rst_n        = 1'b0;
      bus.keys_n_i = 4'hB;
      tick(2);
      rst_n = 1'b1;
      tick(5);
      check_all("held_reset_early", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      tick(1);
      check_all("held_reset_level", 4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
      tick(1);
      check_all("held_reset_press", 4'h4, 4'h4, 4'h0, 4'h0, 1'b0);
      tick(2);
      check_all("held_reset_irq", 4'h4, 4'h0, 4'h4, 4'h0, 1'b1);

`ifdef PANEL_AUTOREPEAT_EN
      // Key3 held 40 clks: pulses 7 (press), 27, 35, 43 clks after the pins go low
      rst_n        = 1'b0;
      bus.keys_n_i = 4'hF;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      bus.keys_n_i = 4'h7;
      for (int t = 1; t <= 70; t++) begin
         if (t == 41) bus.keys_n_i = 4'hF;
         tick(1);
         check($sformatf("repeat t%0d", t), 32'(bus.key_press_o[3]),
               32'((t == 7) || (t == 27) || (t == 35) || (t == 43)));
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
